// File: rtl/odesa_pkg.sv
// Shared ODESA definitions: pattern-entry layout, bus widths and the
// epoch-scheduler state encoding used by the L1/L2 training path.
package odesa_pkg;

    localparam int EVT_W     = 8;
    localparam int LABEL_W   = 4;
    localparam int ENTRY_W   = LABEL_W + EVT_W;
    localparam int LABEL_MSB = 11;
    localparam int LABEL_LSB = 8;
    localparam int EVT_MSB   = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_e;

endpackage

// File: rtl/odesa_pattern_ram.sv
// Pattern table for the epoch scheduler: one synchronous write port and
// one asynchronous read port, contents are not reset.
module odesa_pattern_ram
    import odesa_pkg::*;
#(
    parameter int p_depth  = 16,
    parameter int p_addr_w = 4
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [p_addr_w-1:0] i_waddr,
    input  logic [ENTRY_W-1:0]  i_wdata,
    input  logic [p_addr_w-1:0] i_raddr,
    output logic [ENTRY_W-1:0]  o_rdata
);

    logic [ENTRY_W-1:0] mem_q [p_depth];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/odesa_epoch_scheduler.sv
// Programmable ODESA training sequencer: replays the pattern table for a
// fixed number of epochs, then hands the live event bus through to L1.
module odesa_epoch_scheduler
    import odesa_pkg::*;
#(
    parameter int p_depth   = 16,
    parameter int p_addr_w  = 4,
    parameter int p_epochs  = 100,
    parameter int p_epoch_w = 8,
    parameter int p_gap     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [p_addr_w:0]    i_len,
    input  logic                 i_cfg_we,
    input  logic [p_addr_w-1:0]  i_cfg_addr,
    input  logic [11:0]          i_cfg_data,
    input  logic [7:0]           i_event,
    output logic [7:0]           o_event,
    output logic [3:0]           o_label,
    output logic                 o_endof_epochs,
    output logic                 o_busy,
    output logic [p_epoch_w-1:0] o_epoch,
    output logic [15:0]          o_drop_cnt
);

    localparam int LEN_W = p_addr_w + 1;
    localparam int GW    = (p_gap > 1) ? $clog2(p_gap) : 1;
    localparam logic [LEN_W-1:0]     LEN_MAX = LEN_W'(p_depth);
    localparam logic [p_epoch_w-1:0] EP_LAST = p_epoch_w'(p_epochs - 1);

    state_e                state_q, state_d, adv_state;
    logic [p_addr_w-1:0]   ptr_q, ptr_d, adv_ptr;
    logic [p_epoch_w-1:0]  epoch_q, epoch_d, adv_epoch;
    logic [LEN_W-1:0]      len_q, len_d, len_clamp;
    logic [GW-1:0]         gap_q, gap_d;
    logic [15:0]           drop_q, drop_d;
    logic [EVT_W-1:0]      event_q, event_d;
    logic [LABEL_W-1:0]    label_q, label_d;
    logic [ENTRY_W-1:0]    rd_data;
    logic                  busy;

    assign busy      = (state_q == S_EMIT) || (state_q == S_GAP);
    assign len_clamp = (i_len > LEN_MAX) ? LEN_MAX : i_len;

    odesa_pattern_ram #(
        .p_depth  (p_depth),
        .p_addr_w (p_addr_w)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (i_cfg_we && !busy),
        .i_waddr (i_cfg_addr),
        .i_wdata (i_cfg_data),
        .i_raddr (ptr_d),
        .o_rdata (rd_data)
    );

    // Step to the next entry, wrap into the next epoch, or finish.
    always_comb begin
        adv_state = S_EMIT;
        adv_ptr   = ptr_q + 1'b1;
        adv_epoch = epoch_q;
        if ({1'b0, ptr_q} >= len_q - 1'b1) begin
            adv_ptr = '0;
            if (epoch_q == EP_LAST) begin
                adv_state = S_DONE;
                adv_ptr   = ptr_q;
            end else begin
                adv_epoch = epoch_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        epoch_d = epoch_q;
        len_d   = len_q;
        gap_d   = gap_q;
        drop_d  = drop_q;
        event_d = '0;
        label_d = '0;

        if (busy && (i_event != '0) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    ptr_d   = '0;
                    epoch_d = '0;
                    drop_d  = '0;
                    len_d   = len_clamp;
                    state_d = (len_clamp == '0) ? S_DONE : S_EMIT;
                end
            end
            S_EMIT: begin
                if (p_gap > 0) begin
                    state_d = S_GAP;
                    gap_d   = GW'(p_gap - 1);
                end else begin
                    state_d = adv_state;
                    ptr_d   = adv_ptr;
                    epoch_d = adv_epoch;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = adv_state;
                    ptr_d   = adv_ptr;
                    epoch_d = adv_epoch;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output registers are loaded from the state being entered.
        if (state_d == S_EMIT) begin
            event_d = rd_data[EVT_MSB:0];
            label_d = rd_data[LABEL_MSB:LABEL_LSB];
        end else if (state_d == S_DONE) begin
            event_d = i_event;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            epoch_q <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            drop_q  <= '0;
            event_q <= '0;
            label_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            epoch_q <= epoch_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            drop_q  <= drop_d;
            event_q <= event_d;
            label_q <= label_d;
        end
    end

    assign o_event        = event_q;
    assign o_label        = label_q;
    assign o_endof_epochs = (state_q == S_DONE);
    assign o_busy         = busy;
    assign o_epoch        = epoch_q;
    assign o_drop_cnt     = drop_q;

endmodule

// File: tb/tb_odesa_epoch_scheduler.sv
// Scoreboard bench for odesa_epoch_scheduler: instance A uses a 1-cycle gap,
// instance B runs back-to-back with no gap; both replay two epochs.
module tb_odesa_epoch_scheduler;

    typedef struct packed {
        logic       eoe;
        logic       busy;
        logic [7:0] epoch;
        logic [3:0] label;
        logic [7:0] evt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [4:0]  len;
    logic        we_a, we_b;
    logic [3:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic [7:0]  ev;

    logic [7:0]  evt_a, evt_b;
    logic [3:0]  label_a, label_b;
    logic        eoe_a, eoe_b, busy_a, busy_b;
    logic [7:0]  epoch_a, epoch_b;
    logic [15:0] drop_a, drop_b;

    logic [11:0] tb_mem [16];
    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    odesa_epoch_scheduler #(
        .p_depth(16), .p_addr_w(4), .p_epochs(2), .p_epoch_w(8), .p_gap(1)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_len(len),
        .i_cfg_we(we_a), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .i_event(ev), .o_event(evt_a), .o_label(label_a),
        .o_endof_epochs(eoe_a), .o_busy(busy_a), .o_epoch(epoch_a),
        .o_drop_cnt(drop_a)
    );

    odesa_epoch_scheduler #(
        .p_depth(16), .p_addr_w(4), .p_epochs(2), .p_epoch_w(8), .p_gap(0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_len(len),
        .i_cfg_we(we_b), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .i_event(ev), .o_event(evt_b), .o_label(label_b),
        .o_endof_epochs(eoe_b), .o_busy(busy_b), .o_epoch(epoch_b),
        .o_drop_cnt(drop_b)
    );

    task automatic push_run(input int n, input int gap, input int epochs);
        int   l;
        exp_t e;
        l = (n > 16) ? 16 : n;
        for (int ep = 0; ep < epochs && l > 0; ep++) begin
            for (int p = 0; p < l; p++) begin
                e.eoe   = 1'b0;
                e.busy  = 1'b1;
                e.epoch = 8'(ep);
                e.label = tb_mem[p][11:8];
                e.evt   = tb_mem[p][7:0];
                q.push_back(e);
                for (int g = 0; g < gap; g++) begin
                    e.label = '0;
                    e.evt   = '0;
                    q.push_back(e);
                end
            end
        end
        e.eoe   = 1'b1;
        e.busy  = 1'b0;
        e.epoch = (l > 0) ? 8'(epochs - 1) : 8'd0;
        e.label = '0;
        e.evt   = '0;
        q.push_back(e);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [11:0] d);
        we_a = 1'b1;
        we_b = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        we_a = 1'b0;
        we_b = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic init_table();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) cfg_write(4'(i), 12'h001);
            else if (i == 1) cfg_write(4'(i), 12'h280);
            else if (i == 2) cfg_write(4'(i), 12'h5C3);
            else cfg_write(4'(i), {4'(i), 8'($urandom_range(1, 255))});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({evt_a, label_a, eoe_a, busy_a, epoch_a, drop_a} !== '0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0",
                     {evt_a, label_a, eoe_a, busy_a, epoch_a, drop_a});
        end
        checks++;
        if ({evt_b, label_b, eoe_b, busy_b, epoch_b, drop_b} !== '0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=0",
                     {evt_b, label_b, eoe_b, busy_b, epoch_b, drop_b});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({eoe_a, busy_a, evt_a} !== '0) begin
            failures++;
            $display("FAIL idle_a got=%h exp=0", {eoe_a, busy_a, evt_a});
        end
    endtask

    task automatic test_pattern();
        exp_t e;
        len = 5'd2;
        push_run(2, 1, 2);
        start_a = 1'b1;
        while (q.size() != 0) begin
            @(negedge clk);
            start_a = 1'b0;
            e = q.pop_front();
            checks++;
            if ({eoe_a, busy_a, epoch_a, label_a, evt_a} !== e) begin
                failures++;
                $display("FAIL pattern got=%h exp=%h",
                         {eoe_a, busy_a, epoch_a, label_a, evt_a}, e);
            end
        end
    endtask

    task automatic test_done_passthru();
        ev = 8'hA5;
        @(negedge clk);
        checks++;
        if ({eoe_a, label_a, evt_a, epoch_a} !== {1'b1, 4'h0, 8'hA5, 8'd1}) begin
            failures++;
            $display("FAIL passthru_a5 got=%h exp=%h",
                     {eoe_a, label_a, evt_a, epoch_a}, {1'b1, 4'h0, 8'hA5, 8'd1});
        end
        ev = 8'h5A;
        @(negedge clk);
        checks++;
        if (evt_a !== 8'h5A || label_a !== 4'h0) begin
            failures++;
            $display("FAIL passthru_5a got=%h/%h exp=5a/0", evt_a, label_a);
        end
        ev = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   busy_cnt;
        busy_cnt = 0;
        len = 5'd3;
        push_run(3, 0, 2);
        start_b = 1'b1;
        while (q.size() != 0) begin
            @(negedge clk);
            start_b = 1'b0;
            e = q.pop_front();
            if (busy_b === 1'b1) busy_cnt++;
            checks++;
            if ({eoe_b, busy_b, epoch_b, label_b, evt_b} !== e) begin
                failures++;
                $display("FAIL back_to_back got=%h exp=%h",
                         {eoe_b, busy_b, epoch_b, label_b, evt_b}, e);
            end
        end
        checks++;
        if (busy_cnt != 6) begin
            failures++;
            $display("FAIL b2b_busy_cycles got=%0d exp=6", busy_cnt);
        end
    endtask

    task automatic test_len_clamp();
        exp_t e;
        len = 5'd20;
        push_run(20, 0, 2);
        start_b = 1'b1;
        while (q.size() != 0) begin
            @(negedge clk);
            start_b = 1'b0;
            e = q.pop_front();
            checks++;
            if ({eoe_b, busy_b, epoch_b, label_b, evt_b} !== e) begin
                failures++;
                $display("FAIL len_clamp got=%h exp=%h",
                         {eoe_b, busy_b, epoch_b, label_b, evt_b}, e);
            end
        end
    endtask

    task automatic test_drop_count();
        exp_t e;
        int   k;
        k = 0;
        len = 5'd2;
        push_run(2, 1, 2);
        start_a = 1'b1;
        while (q.size() != 0) begin
            @(negedge clk);
            start_a = 1'b0;
            e = q.pop_front();
            checks++;
            if ({eoe_a, busy_a, epoch_a, label_a, evt_a} !== e) begin
                failures++;
                $display("FAIL drop_evt got=%h exp=%h",
                         {eoe_a, busy_a, epoch_a, label_a, evt_a}, e);
            end
            ev = (k < 5) ? 8'h03 : 8'h00;
            k++;
        end
        checks++;
        if (drop_a !== 16'd5) begin
            failures++;
            $display("FAIL drop_cnt got=%0d exp=5", drop_a);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   k;
        k = 0;
        len = 5'd2;
        push_run(2, 1, 2);
        start_a = 1'b1;
        while (q.size() != 0) begin
            @(negedge clk);
            start_a = 1'b0;
            e = q.pop_front();
            checks++;
            if ({eoe_a, busy_a, epoch_a, label_a, evt_a} !== e) begin
                failures++;
                $display("FAIL sat_evt got=%h exp=%h",
                         {eoe_a, busy_a, epoch_a, label_a, evt_a}, e);
            end
            if (k == 0) begin
                checks++;
                if (drop_a !== 16'd0) begin
                    failures++;
                    $display("FAIL drop_clear got=%h exp=0000", drop_a);
                end
                force dut_a.drop_q = 16'hFFFD;
                release dut_a.drop_q;
            end
            ev = (k < 4) ? 8'h01 : 8'h00;
            k++;
        end
        checks++;
        if (drop_a !== 16'hFFFF) begin
            failures++;
            $display("FAIL drop_sat got=%h exp=ffff", drop_a);
        end
    endtask

    task automatic test_len_zero();
        exp_t e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        len = 5'd0;
        push_run(0, 1, 2);
        start_a = 1'b1;
        while (q.size() != 0) begin
            @(negedge clk);
            start_a = 1'b0;
            e = q.pop_front();
            checks++;
            if ({eoe_a, busy_a, epoch_a, label_a, evt_a} !== e) begin
                failures++;
                $display("FAIL len_zero got=%h exp=%h",
                         {eoe_a, busy_a, epoch_a, label_a, evt_a}, e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({eoe_a, busy_a, evt_a} !== {1'b1, 1'b0, 8'h00}) begin
                failures++;
                $display("FAIL len_zero_hold got=%h exp=200", {eoe_a, busy_a, evt_a});
            end
        end
    endtask

    task automatic test_cfg_ignore();
        exp_t e;
        int   k;
        for (int run = 0; run < 2; run++) begin
            k = 0;
            len = 5'd2;
            push_run(2, 1, 2);
            start_a = 1'b1;
            while (q.size() != 0) begin
                @(negedge clk);
                start_a = 1'b0;
                e = q.pop_front();
                checks++;
                if ({eoe_a, busy_a, epoch_a, label_a, evt_a} !== e) begin
                    failures++;
                    $display("FAIL cfg_ignore run%0d got=%h exp=%h", run,
                             {eoe_a, busy_a, epoch_a, label_a, evt_a}, e);
                end
                we_a = (run == 0 && k < 2);
                cfg_addr = 4'd0;
                cfg_data = 12'hFFF;
                k++;
            end
            we_a = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        len = 5'd2;
        push_run(2, 1, 2);
        start_a = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            e = q.pop_front();
            checks++;
            if ({eoe_a, busy_a, epoch_a, label_a, evt_a} !== e) begin
                failures++;
                $display("FAIL pre_reset got=%h exp=%h",
                         {eoe_a, busy_a, epoch_a, label_a, evt_a}, e);
            end
        end
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        checks++;
        if ({evt_a, label_a, eoe_a, busy_a, epoch_a, drop_a} !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0",
                     {evt_a, label_a, eoe_a, busy_a, epoch_a, drop_a});
        end
        rst = 1'b0;
        push_run(2, 1, 2);
        start_a = 1'b1;
        while (q.size() != 0) begin
            @(negedge clk);
            start_a = 1'b0;
            e = q.pop_front();
            checks++;
            if ({eoe_a, busy_a, epoch_a, label_a, evt_a} !== e) begin
                failures++;
                $display("FAIL replay got=%h exp=%h",
                         {eoe_a, busy_a, epoch_a, label_a, evt_a}, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        len = '0;
        we_a = 1'b0;
        we_b = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        ev = '0;
        @(negedge clk);
        test_reset();
        init_table();
        test_pattern();
        test_done_passthru();
        test_back_to_back();
        test_len_clamp();
        test_drop_count();
        test_saturate();
        test_len_zero();
        test_cfg_ignore();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
